// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, divider helper and bit vote
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } uart_state_e;

  // Clocks per oversample tick, never below one so the tick counter stays legal.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divide-by-DIV counter with sync clear and tick pulse
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == C_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampling UART receiver with valid/ack byte output
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int N_DATA     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       rx_ack_i,
  input  logic       clr_err_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic [1:0] rx_state_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(N_DATA);

  localparam logic [S_W-1:0] S_PRE  = S_W'(M - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(M);
  localparam logic [S_W-1:0] S_DEC  = S_W'(M + 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(N_DATA - 1);

  uart_state_e       r_state;
  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_armed;
  logic [S_W-1:0]    r_s;
  logic [B_W-1:0]    r_bit_idx;
  logic              r_smp0;
  logic              r_smp1;
  logic [N_DATA-1:0] r_shreg;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;

  logic w_start;
  logic w_tick;
  logic w_decide;
  logic w_vote;

  assign w_start  = (r_state == IDLE) && r_armed && !r_rx_s;
  assign w_decide = w_tick && (r_s == S_DEC);
  assign w_vote   = maj3(r_smp0, r_smp1, r_rx_s);

  // Tick phase restarts on the detected start edge so samples land mid-bit.
  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_armed     <= 1'b0;
      r_s         <= '0;
      r_bit_idx   <= '0;
      r_smp0      <= 1'b1;
      r_smp1      <= 1'b1;
      r_shreg     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;

      // Later assignments below override these clears, so a set in the same cycle wins.
      if (clr_err_i) begin
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
      if (r_valid && rx_ack_i) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_rx_s) begin
            r_armed <= 1'b1;
          end
          if (w_start) begin
            r_state <= START_BIT;
            r_s     <= '0;
            r_armed <= 1'b0;
          end
        end
        START_BIT, DATA_BITS, STOP_BIT: begin
          if (w_tick) begin
            r_s <= (r_s == S_LAST) ? '0 : r_s + 1'b1;
            if (r_s == S_PRE) r_smp0 <= r_rx_s;
            if (r_s == S_MID) r_smp1 <= r_rx_s;
          end
          if (w_decide) begin
            case (r_state)
              START_BIT: begin
                if (!w_vote) begin
                  r_state   <= DATA_BITS;
                  r_bit_idx <= '0;
                end else begin
                  r_state <= IDLE;
                end
              end
              DATA_BITS: begin
                r_shreg <= {w_vote, r_shreg[N_DATA-1:1]};
                if (r_bit_idx == B_LAST) begin
                  r_state <= STOP_BIT;
                end else begin
                  r_bit_idx <= r_bit_idx + 1'b1;
                end
              end
              default: begin
                if (w_vote) begin
                  r_data  <= r_shreg;
                  r_valid <= 1'b1;
                  if (r_valid && !rx_ack_i) begin
                    r_overrun <= 1'b1;
                  end
                end else begin
                  r_frame_err <= 1'b1;
                end
                r_state <= IDLE;
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign rx_state_o  = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - directed bench for uart_rx_deserializer
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_ack_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic [1:0] rx_state_o;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] state_log[$];
  logic [1:0] prev_state = 2'd0;
  logic [7:0] seq_packed;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;

  uart_rx_deserializer #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .OVERSAMPLE(16),
    .N_DATA    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (rx_i),
    .rx_ack_i   (rx_ack_i),
    .clr_err_i  (clr_err_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .rx_state_o (rx_state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_state_o !== prev_state) begin
      state_log.push_back(rx_state_o);
      prev_state = rx_state_o;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_i = v;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic ack_at_stop);
    drive(1'b0, 16);
    for (int b = 0; b < 8; b++) drive(d[b], 16);
    if (ack_at_stop) begin
      drive(stop, 12);
      rx_ack_i = 1'b1;
      drive(stop, 1);
      rx_ack_i = 1'b0;
      drive(stop, 3);
    end else begin
      drive(stop, 16);
    end
  endtask

  task automatic pack_log();
    seq_packed = 8'h00;
    foreach (state_log[i]) seq_packed = {seq_packed[5:0], state_log[i]};
  endtask

  task automatic do_ack();
    rx_ack_i = 1'b1;
    @(negedge clk);
    rx_ack_i = 1'b0;
  endtask

  task automatic do_clr();
    clr_err_i = 1'b1;
    @(negedge clk);
    clr_err_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data_o, 8'h00);
    chk("rst_valid", {7'd0, rx_valid_o}, 8'h00);
    chk("rst_ferr", {7'd0, frame_err_o}, 8'h00);
    chk("rst_ovr", {7'd0, overrun_o}, 8'h00);
    chk("rst_state", {6'd0, rx_state_o}, 8'h00);
    rst = 1'b1;
    drive(1'b1, 8);

    // 1: clean frame, state sequence, ack
    state_log.delete();
    send_byte(8'h0B, 1'b1, 1'b0);
    drive(1'b1, 4);
    chk("t1_data", rx_data_o, 8'h0B);
    chk("t1_valid", {7'd0, rx_valid_o}, 8'h01);
    chk("t1_ferr", {7'd0, frame_err_o}, 8'h00);
    pack_log();
    chk("t1_seq", seq_packed, 8'h6C);
    chk("t1_seq_len", 8'(state_log.size()), 8'd4);
    rx_ack_i = 1'b1;
    @(negedge clk);
    rx_ack_i = 1'b0;
    chk("t1_ack_clears", {7'd0, rx_valid_o}, 8'h00);

    // 2: short glitch rejected
    state_log.delete();
    drive(1'b0, 4);
    drive(1'b1, 20);
    chk("t2_state", {6'd0, rx_state_o}, {6'd0, S_IDLE});
    chk("t2_valid", {7'd0, rx_valid_o}, 8'h00);
    chk("t2_flags", {6'd0, frame_err_o, overrun_o}, 8'h00);
    pack_log();
    chk("t2_seq", seq_packed, {4'd0, S_START, S_IDLE});

    // 3: framing error, recovery, clear
    send_byte(8'hA5, 1'b0, 1'b0);
    drive(1'b1, 16);
    chk("t3_ferr_set", {7'd0, frame_err_o}, 8'h01);
    chk("t3_ferr_novalid", {7'd0, rx_valid_o}, 8'h00);
    send_byte(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 4);
    chk("t3_data", rx_data_o, 8'h3C);
    chk("t3_valid", {7'd0, rx_valid_o}, 8'h01);
    chk("t3_ferr_sticky", {7'd0, frame_err_o}, 8'h01);
    do_clr();
    chk("t3_ferr_clr", {7'd0, frame_err_o}, 8'h00);
    do_ack();

    // 4: overrun
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b0);
    drive(1'b1, 4);
    chk("t4_data", rx_data_o, 8'h22);
    chk("t4_ovr", {7'd0, overrun_o}, 8'h01);
    chk("t4_valid", {7'd0, rx_valid_o}, 8'h01);
    do_clr();
    chk("t4_ovr_clr", {7'd0, overrun_o}, 8'h00);
    do_ack();

    // 5: ack coincident with stop decision
    send_byte(8'h11, 1'b1, 1'b0);
    chk("t5_first_valid", {7'd0, rx_valid_o}, 8'h01);
    send_byte(8'h22, 1'b1, 1'b1);
    drive(1'b1, 4);
    chk("t5_data", rx_data_o, 8'h22);
    chk("t5_valid", {7'd0, rx_valid_o}, 8'h01);
    chk("t5_no_ovr", {7'd0, overrun_o}, 8'h00);

    // 6: async reset mid-frame during bit 3 of 0x77
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b1, 16);
    drive(1'b0, 8);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_data", rx_data_o, 8'h00);
    chk("t6_rst_valid", {7'd0, rx_valid_o}, 8'h00);
    chk("t6_rst_state", {6'd0, rx_state_o}, 8'h00);
    chk("t6_rst_flags", {6'd0, frame_err_o, overrun_o}, 8'h00);
    @(negedge clk);
    rx_i = 1'b1;
    rst = 1'b1;
    drive(1'b1, 8);
    send_byte(8'h5A, 1'b1, 1'b0);
    drive(1'b1, 4);
    chk("t6_data", rx_data_o, 8'h5A);
    chk("t6_valid", {7'd0, rx_valid_o}, 8'h01);
    chk("t6_flags", {6'd0, frame_err_o, overrun_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
